// File: rtl/riscv_trace_pkg.sv
// riscv_trace_pkg: shared types and constants for the retirement-trace logger.
//   REC_BYTES  bytes per serialised record (8, or 12 with TRACE_TIMESTAMP_EN)
//   REC_W      record width in bits
//   trace_state_t  serialiser states
//   FAIL_INSTR_DEFAULT  instruction word marking a failed self-test step
// Config macro: TRACE_TIMESTAMP_EN appends a 32-bit cycle timestamp to each record.
package riscv_trace_pkg;

`ifdef TRACE_TIMESTAMP_EN
  localparam int unsigned REC_BYTES = 12;
`else
  localparam int unsigned REC_BYTES = 8;
`endif
  localparam int unsigned REC_W = 8 * REC_BYTES;

  localparam logic [31:0] FAIL_INSTR_DEFAULT = 32'h001e6e13;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND
  } trace_state_t;

endpackage

// File: rtl/riscv_trace_logger_if.sv
// riscv_trace_logger_if: byte-stream handshake from the trace logger to its consumer.
//   byte_o        serialised record byte
//   byte_valid_o  byte_o valid
//   byte_ready_i  consumer accepts byte_o this cycle
// master = trace logger (producer), slave = consumer (e.g. UART TX).
interface riscv_trace_logger_if;
  logic [7:0] byte_o;
  logic       byte_valid_o;
  logic       byte_ready_i;

  modport master (output byte_o, output byte_valid_o, input byte_ready_i);
  modport slave  (input byte_o, input byte_valid_o, output byte_ready_i);
endinterface

// File: rtl/riscv_trace_fifo.sv
// riscv_trace_fifo: synchronous FIFO, WIDTH x DEPTH (DEPTH power of two, >= 2).
//   clk, rst_n  clock, asynchronous active-low reset
//   push/wdata  write request / data (ignored while full unless popping the same cycle)
//   pop/rdata   read request / head entry (rdata shows the head combinationally)
//   full/empty  registered status flags
module riscv_trace_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic             do_push, do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign wr_nxt  = wr_ptr + PW'(do_push);
  assign rd_nxt  = rd_ptr + PW'(do_pop);

  // Flags are computed from the next pointers so they are registered yet
  // agree with the occupancy in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      empty  <= (wr_nxt == rd_nxt);
      full   <= (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/riscv_trace_logger.sv
// riscv_trace_logger: retirement-trace stage. Queues each retired {instruction, result}
// pair, flags the fail-marker instruction and serialises records MSB-first as bytes.
//   CLK, RST         clock, asynchronous active-low reset
//   instr_valid_i    strobe: instruction_i/result_i hold a retired pair
//   instruction_i    retired instruction word
//   result_i         retired result value
//   bus (master)     byte_o / byte_valid_o / byte_ready_i stream
//   fifo_full_o      FIFO holds DEPTH records
//   fifo_empty_o     FIFO holds no records
//   overflow_o       sticky: a record was dropped
//   fail_o           sticky: FAIL_INSTR retired
//   fail_count_o     FAIL_INSTR occurrences, saturating
//   record_count_o   records accepted into the FIFO, wrapping
// Config macro: TRACE_TIMESTAMP_EN stores a 32-bit cycle stamp per record (12-byte records).
module riscv_trace_logger
  import riscv_trace_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter logic [31:0] FAIL_INSTR = FAIL_INSTR_DEFAULT
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 instr_valid_i,
  input  logic [31:0]          instruction_i,
  input  logic [31:0]          result_i,
  riscv_trace_logger_if.master bus,
  output logic                 fifo_full_o,
  output logic                 fifo_empty_o,
  output logic                 overflow_o,
  output logic                 fail_o,
  output logic [15:0]          fail_count_o,
  output logic [31:0]          record_count_o
);
  localparam int unsigned      IDX_W    = $clog2(REC_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REC_BYTES - 1);

  trace_state_t     state;
  logic [REC_W-1:0] shreg, head, rec_in;
  logic [IDX_W-1:0] byte_idx;
  logic             beat, last_beat, pop, push;

  assign beat      = bus.byte_valid_o && bus.byte_ready_i;
  assign last_beat = beat && (byte_idx == LAST_IDX);
  assign pop       = (state == LOAD) || (last_beat && !fifo_empty_o);
  assign push      = instr_valid_i && (!fifo_full_o || pop);

`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] cycle_cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) cycle_cnt <= '0;
    else      cycle_cnt <= cycle_cnt + 32'd1;
  end

  assign rec_in = {instruction_i, result_i, cycle_cnt};
`else
  assign rec_in = {instruction_i, result_i};
`endif

  riscv_trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST),
    .push  (push),
    .wdata (rec_in),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full_o),
    .empty (fifo_empty_o)
  );

  // Serialiser. The reload for a following record is folded into the final
  // SEND beat so back-to-back records stream without a bubble.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state            <= IDLE;
      shreg            <= '0;
      byte_idx         <= '0;
      bus.byte_valid_o <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (!fifo_empty_o) state <= LOAD;
        LOAD: begin
          shreg            <= head;
          byte_idx         <= '0;
          bus.byte_valid_o <= 1'b1;
          state            <= SEND;
        end
        SEND: if (beat) begin
          if (byte_idx == LAST_IDX) begin
            if (!fifo_empty_o) begin
              shreg    <= head;
              byte_idx <= '0;
            end else begin
              bus.byte_valid_o <= 1'b0;
              state            <= IDLE;
            end
          end else begin
            shreg    <= shreg << 8;
            byte_idx <= byte_idx + IDX_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.byte_o = shreg[REC_W-1 -: 8];

  // Fail detection looks at every strobe, including ones dropped on overflow.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      overflow_o     <= 1'b0;
      fail_o         <= 1'b0;
      fail_count_o   <= '0;
      record_count_o <= '0;
    end else begin
      if (push) record_count_o <= record_count_o + 32'd1;
      if (instr_valid_i && !push) overflow_o <= 1'b1;
      if (instr_valid_i && (instruction_i == FAIL_INSTR)) begin
        fail_o <= 1'b1;
        if (fail_count_o != '1) fail_count_o <= fail_count_o + 16'd1;
      end
    end
  end

endmodule
